// File: rtl/msg_sched_pkg.sv
// rtl/msg_sched_pkg.sv - shared constants and types for the SHA-2 message schedule engine
package msg_sched_pkg;

    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] sh;
    } sigma_cfg_t;

    localparam sigma_cfg_t SHA256_S0 = '{r0: 8'd7,  r1: 8'd18, sh: 8'd3};
    localparam sigma_cfg_t SHA256_S1 = '{r0: 8'd17, r1: 8'd19, sh: 8'd10};
    localparam sigma_cfg_t SHA512_S0 = '{r0: 8'd1,  r1: 8'd8,  sh: 8'd7};
    localparam sigma_cfg_t SHA512_S1 = '{r0: 8'd19, r1: 8'd61, sh: 8'd6};

    localparam int NROUNDS_256 = 64;
    localparam int NROUNDS_512 = 80;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DRAIN
    } state_t;

endpackage

// File: rtl/msg_sched_stream_if.sv
// rtl/msg_sched_stream_if.sv - message-word input stream and schedule-word output stream
interface msg_sched_stream_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/msg_sched_sigma.sv
// rtl/msg_sched_sigma.sv - combinational sigma: rotr(x,r0) ^ rotr(x,r1) ^ (x >> sh)
module msg_sched_sigma #(
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] x,
    input  logic [SH_W-1:0]   r0,
    input  logic [SH_W-1:0]   r1,
    input  logic [SH_W-1:0]   sh,
    output logic [DATA_W-1:0] y
);
    logic [SH_W:0]       inv0;
    logic [SH_W:0]       inv1;
    logic [DATA_W-1:0]   rot0;
    logic [DATA_W-1:0]   rot1;

    // A zero rotate gives a left shift by DATA_W, which correctly yields 0.
    assign inv0 = (SH_W + 1)'(DATA_W) - {1'b0, r0};
    assign inv1 = (SH_W + 1)'(DATA_W) - {1'b0, r1};
    assign rot0 = (x >> r0) | (x << inv0);
    assign rot1 = (x >> r1) | (x << inv1);
    assign y    = rot0 ^ rot1 ^ (x >> sh);
endmodule

// File: rtl/msg_sched_stream.sv
// rtl/msg_sched_stream.sv - streaming SHA-2 message schedule with 16-word window and backpressure
module msg_sched_stream
    import msg_sched_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NROUNDS = NROUNDS_256,
    parameter int SH_W    = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              done,
    input  logic [SH_W-1:0]   s0_r0,
    input  logic [SH_W-1:0]   s0_r1,
    input  logic [SH_W-1:0]   s0_sh,
    input  logic [SH_W-1:0]   s1_r0,
    input  logic [SH_W-1:0]   s1_r1,
    input  logic [SH_W-1:0]   s1_sh,
    msg_sched_stream_if.slave strm
);
    localparam logic [7:0] T_LAST = 8'(NROUNDS - 1);

    state_t            state;
    logic [7:0]        t;
    logic [DATA_W-1:0] win [16];
    logic [DATA_W-1:0] s0_val;
    logic [DATA_W-1:0] s1_val;
    logic [DATA_W-1:0] new_word;
    logic [DATA_W-1:0] shift_word;
    logic              slot_free;
    logic              in_fire;
    logic              exp_fire;
    logic              shift_en;

    msg_sched_sigma #(.DATA_W(DATA_W), .SH_W(SH_W)) u_sigma0 (
        .x  (win[1]),
        .r0 (s0_r0),
        .r1 (s0_r1),
        .sh (s0_sh),
        .y  (s0_val)
    );

    msg_sched_sigma #(.DATA_W(DATA_W), .SH_W(SH_W)) u_sigma1 (
        .x  (win[14]),
        .r0 (s1_r0),
        .r1 (s1_r1),
        .sh (s1_sh),
        .y  (s1_val)
    );

    // win[15] is W[t-1], so W[t-2], W[t-7], W[t-15], W[t-16] sit at 14, 9, 1, 0.
    assign new_word   = s1_val + win[9] + s0_val + win[0];
    assign slot_free  = !strm.out_valid || strm.out_ready;
    assign strm.in_ready = (state == LOAD) && slot_free;
    assign in_fire    = strm.in_valid && strm.in_ready;
    assign exp_fire   = (state == EXPAND) && slot_free;
    assign shift_en   = in_fire || exp_fire;
    assign shift_word = in_fire ? strm.in_data : new_word;

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && run)) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (shift_en) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= shift_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            t              <= '0;
            done           <= 1'b1;
            strm.out_valid <= 1'b0;
            strm.out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= LOAD;
                        t     <= '0;
                        done  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        strm.out_data  <= strm.in_data;
                        strm.out_valid <= 1'b1;
                        t              <= t + 8'd1;
                        if (t == 8'd15) begin
                            state <= EXPAND;
                        end
                    end else if (strm.out_ready) begin
                        strm.out_valid <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (slot_free) begin
                        strm.out_data  <= new_word;
                        strm.out_valid <= 1'b1;
                        if (t == T_LAST) begin
                            state <= DRAIN;
                        end else begin
                            t <= t + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (strm.out_ready) begin
                        strm.out_valid <= 1'b0;
                        state          <= IDLE;
                        done           <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msg_sched_stream.sv
// tb/tb_msg_sched_stream.sv - scoreboard bench for SHA-256 and SHA-512 schedule instances
module tb_msg_sched_stream;
    import msg_sched_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic run32, run64;
    logic done32, done64;

    msg_sched_stream_if #(.DATA_W(32)) if32 ();
    msg_sched_stream_if #(.DATA_W(64)) if64 ();

    msg_sched_stream #(.DATA_W(32), .NROUNDS(NROUNDS_256)) u32 (
        .clk   (clk),
        .rst   (rst),
        .run   (run32),
        .done  (done32),
        .s0_r0 (5'(SHA256_S0.r0)),
        .s0_r1 (5'(SHA256_S0.r1)),
        .s0_sh (5'(SHA256_S0.sh)),
        .s1_r0 (5'(SHA256_S1.r0)),
        .s1_r1 (5'(SHA256_S1.r1)),
        .s1_sh (5'(SHA256_S1.sh)),
        .strm  (if32)
    );

    msg_sched_stream #(.DATA_W(64), .NROUNDS(NROUNDS_512)) u64 (
        .clk   (clk),
        .rst   (rst),
        .run   (run64),
        .done  (done64),
        .s0_r0 (6'(SHA512_S0.r0)),
        .s0_r1 (6'(SHA512_S0.r1)),
        .s0_sh (6'(SHA512_S0.sh)),
        .s1_r0 (6'(SHA512_S1.r0)),
        .s1_r1 (6'(SHA512_S1.r1)),
        .s1_sh (6'(SHA512_S1.sh)),
        .strm  (if64)
    );

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [63:0] feed_q [2][$];
    logic [63:0] exp_q  [2][$];
    logic [63:0] got_q  [2][$];
    int          acc    [2];
    bit          hold   [2];
    logic [63:0] hold_d [2];
    bit          bub    [2];
    bit          stall_en = 1'b0;
    bit          gap_en   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_asrt++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int a, input int wd);
        logic [63:0] m;
        m = (wd == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return ((x >> a) | (x << (wd - a))) & m;
    endfunction

    function automatic logic [63:0] sig(input logic [63:0] x, input sigma_cfg_t c, input int wd);
        return rotr(x, int'(c.r0), wd) ^ rotr(x, int'(c.r1), wd) ^ (x >> c.sh);
    endfunction

    // One clock: drive ready/run, sample just after the falling edge, score outputs, offer input.
    task automatic tick(input bit r32 = 1'b0, input bit r64 = 1'b0);
        bit          ov [2];
        bit          ir [2];
        bit          rdy [2];
        bit          iv [2];
        logic [63:0] od [2];
        logic [63:0] id [2];
        @(negedge clk);
        run32 = r32;
        run64 = r64;
        rdy[0] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        rdy[1] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if32.out_ready = rdy[0];
        if64.out_ready = rdy[1];
        #1;
        ov[0] = if32.out_valid;
        od[0] = 64'(if32.out_data);
        ir[0] = if32.in_ready;
        ov[1] = if64.out_valid;
        od[1] = if64.out_data;
        ir[1] = if64.in_ready;
        for (int d = 0; d < 2; d++) begin
            if (hold[d]) begin
                chk($sformatf("stall_valid%0d", d), 64'(ov[d]), 64'd1);
                chk($sformatf("stall_data%0d", d), od[d], hold_d[d]);
            end
            if (bub[d]) chk($sformatf("no_bubble%0d", d), 64'(ov[d]), 64'd1);
            bub[d] = 1'b0;
            if (ov[d] && !rdy[d]) chk($sformatf("in_ready_stall%0d", d), 64'(ir[d]), 64'd0);
            if (acc[d] >= 16) chk($sformatf("in_ready_after16_%0d", d), 64'(ir[d]), 64'd0);
            if (ov[d] && rdy[d]) begin
                got_q[d].push_back(od[d]);
                chk($sformatf("word_expected%0d", d), 64'(exp_q[d].size() > 0), 64'd1);
                if (exp_q[d].size() > 0)
                    chk($sformatf("out_data%0d_w%0d", d, got_q[d].size() - 1), od[d], exp_q[d].pop_front());
                if (got_q[d].size() == 16 && !stall_en) bub[d] = 1'b1;
            end
            hold[d]   = !rst && ov[d] && !rdy[d];
            hold_d[d] = od[d];
            iv[d] = (feed_q[d].size() > 0) && (!gap_en || $urandom_range(0, 1) == 1);
            id[d] = iv[d] ? feed_q[d][0] : 64'd0;
            if (iv[d] && ir[d]) begin
                void'(feed_q[d].pop_front());
                acc[d]++;
            end
        end
        if32.in_valid = iv[0];
        if32.in_data  = id[0][31:0];
        if64.in_valid = iv[1];
        if64.in_data  = id[1];
    endtask

    task automatic start_block(input int d, input logic [63:0] m [16]);
        int          wd;
        int          nr;
        sigma_cfg_t  c0;
        sigma_cfg_t  c1;
        logic [63:0] mask;
        logic [63:0] w [80];
        wd   = (d == 1) ? 64 : 32;
        nr   = (d == 1) ? NROUNDS_512 : NROUNDS_256;
        c0   = (d == 1) ? SHA512_S0 : SHA256_S0;
        c1   = (d == 1) ? SHA512_S1 : SHA256_S1;
        mask = (d == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            w[i] = m[i] & mask;
            feed_q[d].push_back(w[i]);
        end
        for (int i = 16; i < nr; i++)
            w[i] = (sig(w[i-2], c1, wd) + w[i-7] + sig(w[i-15], c0, wd) + w[i-16]) & mask;
        for (int i = 0; i < nr; i++) exp_q[d].push_back(w[i]);
        acc[d] = 0;
        got_q[d].delete();
        tick(d == 0, d == 1);
    endtask

    task automatic wait_done(input int d, output int cycles, input int run_a = -1, input int run_b = -1);
        bit pulse;
        bit fin;
        cycles = 0;
        fin    = 1'b0;
        while (!fin && cycles < 600) begin
            pulse = (cycles == run_a) || (cycles == run_b);
            tick(d == 0 && pulse, d == 1 && pulse);
            cycles++;
            fin = ((d == 1) ? done64 : done32) === 1'b1 && exp_q[d].size() == 0;
        end
        chk($sformatf("done_in_budget%0d", d), 64'(fin), 64'd1);
    endtask

    logic [63:0] abc256 [16];
    logic [63:0] abc512 [16];
    logic [63:0] rnd    [16];
    int          cyc;

    initial begin
        for (int i = 0; i < 16; i++) begin
            abc256[i] = 64'd0;
            abc512[i] = 64'd0;
        end
        abc256[0]  = 64'h0000_0000_6162_6380;
        abc256[15] = 64'h18;
        abc512[0]  = 64'h6162_6380_0000_0000;
        abc512[15] = 64'h18;
        for (int d = 0; d < 2; d++) begin
            acc[d]  = 0;
            hold[d] = 1'b0;
            bub[d]  = 1'b0;
        end
        rst = 1'b1;
        run32 = 1'b0;
        run64 = 1'b0;
        if32.in_valid = 1'b0; if32.in_data = '0; if32.out_ready = 1'b1;
        if64.in_valid = 1'b0; if64.in_data = '0; if64.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid32", 64'(if32.out_valid), 64'd0);
        chk("rst_out_data32", 64'(if32.out_data), 64'd0);
        chk("rst_done32", 64'(done32), 64'd1);
        chk("rst_in_ready32", 64'(if32.in_ready), 64'd0);
        chk("rst_out_valid64", 64'(if64.out_valid), 64'd0);
        chk("rst_out_data64", if64.out_data, 64'd0);
        chk("rst_done64", 64'(done64), 64'd1);
        rst = 1'b0;

        // SHA-256 "abc", continuous flow
        start_block(0, abc256);
        wait_done(0, cyc);
        chk("latency256", 64'(cyc), 64'(NROUNDS_256 + 2));
        chk("count256", 64'(got_q[0].size()), 64'd64);
        chk("w16_abc", got_q[0][16], 64'h6162_6380);
        chk("w17_abc", got_q[0][17], 64'h000F_0000);

        // Random output stalls on the same block
        stall_en = 1'b1;
        start_block(0, abc256);
        wait_done(0, cyc);
        chk("count256_stall", 64'(got_q[0].size()), 64'd64);
        stall_en = 1'b0;

        // Input gaps during LOAD, random message
        gap_en = 1'b1;
        for (int i = 0; i < 16; i++) rnd[i] = 64'($urandom);
        start_block(0, rnd);
        wait_done(0, cyc);
        chk("accepted16", 64'(acc[0]), 64'd16);
        gap_en = 1'b0;

        // Reset in the middle of EXPAND, then a fresh block
        start_block(0, abc256);
        cyc = 0;
        while (got_q[0].size() < 30 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("reached_t30", 64'(got_q[0].size()), 64'd30);
        rst = 1'b1;
        exp_q[0].delete();
        feed_q[0].delete();
        tick();
        chk("midrst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("midrst_done", 64'(done32), 64'd1);
        chk("midrst_in_ready", 64'(if32.in_ready), 64'd0);
        rst = 1'b0;
        start_block(0, abc256);
        wait_done(0, cyc);
        chk("count256_after_rst", 64'(got_q[0].size()), 64'd64);

        // Stray run pulses in LOAD and EXPAND, then a back-to-back block
        start_block(0, abc256);
        wait_done(0, cyc, 5, 40);
        chk("count256_stray_run", 64'(got_q[0].size()), 64'd64);
        for (int i = 0; i < 16; i++) rnd[i] = 64'($urandom);
        start_block(0, rnd);
        wait_done(0, cyc);
        chk("count256_b2b", 64'(got_q[0].size()), 64'd64);

        // SHA-512 "abc"
        start_block(1, abc512);
        wait_done(1, cyc);
        chk("latency512", 64'(cyc), 64'(NROUNDS_512 + 2));
        chk("count512", 64'(got_q[1].size()), 64'd80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
